fetch_dispatch_sequencer: RTL and testbench
===========================================

Name: fetch_dispatch_sequencer

Overview:
Command sequencer placed in front of the fetcher/dispatcher wrapper. It accepts a stream of FETCH and DISPATCH commands from the master control path, buffers them in an in-order queue, and issues single-cycle enable pulses with held argument buses. It waits for the matching done pulses and enforces per-side hazards on the shared dispatcher buffer, so that a FETCH into side S and a DISPATCH from side S never overlap. FETCH and DISPATCH on opposite sides may run concurrently.

Parameters:
CMD_DEPTH, 4, command queue depth (power of 2, >=2)
ADDR_WIDTH, 25, fetch address width (matches link address width)
LEN_WIDTH, 16, fetch length width (matches link length width)
TIMEOUT_CYCLES, 65535, cycles an engine may stay busy before forced release; 0 disables the watchdog

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  queue not full
i_cmd_op  in  1  0=FETCH, 1=DISPATCH
i_cmd_side  in  1  0=left, 1=right (fetch target / dispatch side)
i_cmd_fetch_addr  in  ADDR_WIDTH  FETCH source address
i_cmd_fetch_len  in  LEN_WIDTH  FETCH length
i_cmd_tile_addr  in  16  DISPATCH tile address
i_cmd_nv_cnt  in  8  DISPATCH total NVs
i_cmd_ugd_vec_size  in  8  DISPATCH NVs per UGD vector
i_cmd_man_4b  in  1  DISPATCH mantissa width select
i_cmd_col_en  in  24  DISPATCH column mask
i_cmd_col_start  in  5  DISPATCH start column
i_cmd_broadcast  in  1  DISPATCH broadcast mode
o_fetch_en  out  1  one-cycle FETCH start
o_fetch_addr / o_fetch_len / o_fetch_target  out  ADDR_WIDTH / LEN_WIDTH / 1  FETCH arguments
i_fetch_done  in  1  FETCH completion pulse
o_disp_en  out  1  one-cycle DISPATCH start
o_disp_tile_addr, o_disp_man_nv_cnt, o_disp_ugd_vec_size, o_disp_man_4b, o_disp_col_en, o_disp_col_start, o_disp_right, o_disp_broadcast  out  16,8,8,1,24,5,1,1  DISPATCH arguments
i_disp_done  in  1  DISPATCH completion pulse
o_fetch_busy / o_disp_busy  out  1 / 1  engine outstanding
o_idle  out  1  queue empty and both engines idle
o_cmd_count  out  $clog2(CMD_DEPTH)+1  queue occupancy
o_err_timeout  out  2  sticky watchdog flags {disp,fetch}
i_err_clr  in  1  clears o_err_timeout

Behaviour:
- Reset: all outputs 0 except o_cmd_ready=1 and o_idle=1. Queue is flushed and engine states cleared. Reset mid-operation abandons outstanding operations, and a later done pulse is ignored because the engine is not busy.
- Push: occurs when i_cmd_valid & o_cmd_ready. o_cmd_ready = (count != CMD_DEPTH), taken from the registered count, so a same-cycle pop does not raise ready. Pushes while not ready are dropped.
- Issue is strictly in order, at most one command per cycle, from the queue head only.
- Head FETCH on side S issues when the fetch engine is free and no DISPATCH on side S is outstanding.
- Head DISPATCH on side S issues when the dispatch engine is free and no FETCH on side S is outstanding.
- "Free/not outstanding" is evaluated as busy & ~done, so a done pulse at cycle d allows a dependent issue with enable high at d+1.
- A blocked head stalls all later commands; there is no reordering.
- Per-engine FSM: IDLE -> BUSY on issue; BUSY -> IDLE on done or watchdog expiry.
  - Enable is registered and high for exactly the issue cycle.
  - Argument outputs load in that same cycle and hold until the next issue of that engine.
  - The busy flag rises in the enable cycle.
- Done pulses are ignored when the engine is IDLE and in the enable cycle itself.
- Latency: a push into an empty queue with a free engine at cycle t gives enable at t+1.
- Watchdog: a per-engine counter resets on issue and increments while BUSY. When it reaches TIMEOUT_CYCLES (non-zero), the engine is forced IDLE and its o_err_timeout bit is set. A simultaneous done takes priority and sets no error.
- i_err_clr clears both flags. If i_err_clr and a new timeout occur in the same cycle, the flag stays set.
- Simultaneous push and pop update count by 0. count never exceeds CMD_DEPTH, and queue pointers wrap modulo CMD_DEPTH.
- o_idle = (count==0) & ~o_fetch_busy & ~o_disp_busy.

Test Plan:
- Push FETCH(side0, addr 0x100, len 528) at t0 -> o_fetch_en=1 at t0+1 with addr 0x100, len 528, target 0; o_fetch_busy=1 until the cycle after i_fetch_done.
- FETCH side0 then DISPATCH side0 (nv_cnt 128, col_en 0x00000F) -> o_disp_en stays 0 until i_fetch_done at d, then asserts exactly at d+1 with all fields correct.
- FETCH side1 then DISPATCH side0 with fetch outstanding -> o_disp_en asserts one cycle after o_fetch_en, concurrently with the busy fetch.
- Push 5 commands with CMD_DEPTH=4 and engines stalled -> o_cmd_ready=0 after the 4th, the 5th is dropped, o_cmd_count=4, and issue order matches push order.
- TIMEOUT_CYCLES=10, issue FETCH with no done -> after 10 busy cycles o_fetch_busy=0 and o_err_timeout=2'b01; i_err_clr clears the flag. A done pulse arriving later is ignored.
- Assert i_reset_n=0 with a DISPATCH outstanding and 2 queued -> count=0, o_idle=1, no enables; a stray i_disp_done after release causes no issue.

Source files
------------

// File: rtl/fetch_dispatch_sequencer.sv
// In-order FETCH/DISPATCH command sequencer with per-side hazards on the shared buffer; enable 1 cycle after push when free.
// Backpressure: o_cmd_ready drops when the queue is full (registered count); a blocked head stalls every later command.

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push    = i_push && (count_q != (AW+1)'(DEPTH));
    assign do_pop     = i_pop && (count_q != '0);
    assign o_head_dat = mem_q[rd_ptr_q];
    assign o_count    = count_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_push_dat;
    end
endmodule

module fetch_dispatch_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int ADDR_WIDTH     = 25,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_op,
    input  logic                          i_cmd_side,
    input  logic [ADDR_WIDTH-1:0]         i_cmd_fetch_addr,
    input  logic [LEN_WIDTH-1:0]          i_cmd_fetch_len,
    input  logic [15:0]                   i_cmd_tile_addr,
    input  logic [7:0]                    i_cmd_nv_cnt,
    input  logic [7:0]                    i_cmd_ugd_vec_size,
    input  logic                          i_cmd_man_4b,
    input  logic [23:0]                   i_cmd_col_en,
    input  logic [4:0]                    i_cmd_col_start,
    input  logic                          i_cmd_broadcast,
    output logic                          o_fetch_en,
    output logic [ADDR_WIDTH-1:0]         o_fetch_addr,
    output logic [LEN_WIDTH-1:0]          o_fetch_len,
    output logic                          o_fetch_target,
    input  logic                          i_fetch_done,
    output logic                          o_disp_en,
    output logic [15:0]                   o_disp_tile_addr,
    output logic [7:0]                    o_disp_man_nv_cnt,
    output logic [7:0]                    o_disp_ugd_vec_size,
    output logic                          o_disp_man_4b,
    output logic [23:0]                   o_disp_col_en,
    output logic [4:0]                    o_disp_col_start,
    output logic                          o_disp_right,
    output logic                          o_disp_broadcast,
    input  logic                          i_disp_done,
    output logic                          o_fetch_busy,
    output logic                          o_disp_busy,
    output logic                          o_idle,
    output logic [$clog2(CMD_DEPTH):0]    o_cmd_count,
    output logic [1:0]                    o_err_timeout,
    input  logic                          i_err_clr
);
    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef struct packed {
        logic                  op;
        logic                  side;
        logic [ADDR_WIDTH-1:0] fetch_addr;
        logic [LEN_WIDTH-1:0]  fetch_len;
        logic [15:0]           tile_addr;
        logic [7:0]            nv_cnt;
        logic [7:0]            ugd_vec_size;
        logic                  man_4b;
        logic [23:0]           col_en;
        logic [4:0]            col_start;
        logic                  broadcast;
    } cmd_t;

    typedef enum logic {ENG_IDLE, ENG_BUSY} eng_state_e;

    cmd_t            in_cmd;
    cmd_t            fifo_head;
    cmd_t            head_cmd;
    logic [CW-1:0]   count;
    logic            q_empty;
    logic            push;
    logic            head_vld;
    logic            fifo_push;
    logic            fifo_pop;

    eng_state_e      fetch_state_q;
    eng_state_e      disp_state_q;
    logic [TW-1:0]   fetch_cnt_q;
    logic [TW-1:0]   disp_cnt_q;
    logic            fetch_en_q;
    logic            disp_en_q;
    logic [ADDR_WIDTH-1:0] fetch_addr_q;
    logic [LEN_WIDTH-1:0]  fetch_len_q;
    logic            fetch_target_q;
    logic [15:0]     disp_tile_q;
    logic [7:0]      disp_nv_q;
    logic [7:0]      disp_ugd_q;
    logic            disp_man_q;
    logic [23:0]     disp_col_en_q;
    logic [4:0]      disp_col_start_q;
    logic            disp_right_q;
    logic            disp_bc_q;
    logic [1:0]      err_q;

    logic            fetch_busy;
    logic            disp_busy;
    logic            fetch_done_eff;
    logic            disp_done_eff;
    logic            fetch_out;
    logic            disp_out;
    logic            fetch_expire;
    logic            disp_expire;
    logic            issue_fetch;
    logic            issue_disp;

    assign in_cmd = '{op: i_cmd_op, side: i_cmd_side, fetch_addr: i_cmd_fetch_addr,
                      fetch_len: i_cmd_fetch_len, tile_addr: i_cmd_tile_addr,
                      nv_cnt: i_cmd_nv_cnt, ugd_vec_size: i_cmd_ugd_vec_size,
                      man_4b: i_cmd_man_4b, col_en: i_cmd_col_en,
                      col_start: i_cmd_col_start, broadcast: i_cmd_broadcast};

    fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_q (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_push     (fifo_push),
        .i_push_dat (in_cmd),
        .i_pop      (fifo_pop),
        .o_head_dat (fifo_head),
        .o_count    (count)
    );

    assign q_empty     = (count == '0);
    assign o_cmd_ready = (count != CW'(CMD_DEPTH));
    assign push        = i_cmd_valid && o_cmd_ready;

    // An empty queue presents the incoming command as head so it can issue in the push cycle.
    assign head_vld = !q_empty || push;
    assign head_cmd = q_empty ? in_cmd : fifo_head;

    assign fetch_busy     = (fetch_state_q == ENG_BUSY);
    assign disp_busy      = (disp_state_q == ENG_BUSY);
    assign fetch_done_eff = fetch_busy && !fetch_en_q && i_fetch_done;
    assign disp_done_eff  = disp_busy && !disp_en_q && i_disp_done;
    assign fetch_out      = fetch_busy && !fetch_done_eff;
    assign disp_out       = disp_busy && !disp_done_eff;
    assign fetch_expire   = (TIMEOUT_CYCLES != 0) && fetch_out && (fetch_cnt_q == TO_LAST);
    assign disp_expire    = (TIMEOUT_CYCLES != 0) && disp_out && (disp_cnt_q == TO_LAST);

    assign issue_fetch = head_vld && !head_cmd.op && !fetch_out &&
                         !(disp_out && (disp_right_q == head_cmd.side));
    assign issue_disp  = head_vld && head_cmd.op && !disp_out &&
                         !(fetch_out && (fetch_target_q == head_cmd.side));

    assign fifo_push = push && !(q_empty && (issue_fetch || issue_disp));
    assign fifo_pop  = !q_empty && (issue_fetch || issue_disp);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fetch_state_q  <= ENG_IDLE;
            fetch_en_q     <= 1'b0;
            fetch_cnt_q    <= '0;
            fetch_addr_q   <= '0;
            fetch_len_q    <= '0;
            fetch_target_q <= 1'b0;
        end else begin
            fetch_en_q <= issue_fetch;
            if (issue_fetch) begin
                fetch_state_q  <= ENG_BUSY;
                fetch_cnt_q    <= '0;
                fetch_addr_q   <= head_cmd.fetch_addr;
                fetch_len_q    <= head_cmd.fetch_len;
                fetch_target_q <= head_cmd.side;
            end else if (fetch_busy) begin
                fetch_cnt_q <= fetch_cnt_q + TW'(1);
                if (fetch_done_eff || fetch_expire) fetch_state_q <= ENG_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            disp_state_q     <= ENG_IDLE;
            disp_en_q        <= 1'b0;
            disp_cnt_q       <= '0;
            disp_tile_q      <= '0;
            disp_nv_q        <= '0;
            disp_ugd_q       <= '0;
            disp_man_q       <= 1'b0;
            disp_col_en_q    <= '0;
            disp_col_start_q <= '0;
            disp_right_q     <= 1'b0;
            disp_bc_q        <= 1'b0;
        end else begin
            disp_en_q <= issue_disp;
            if (issue_disp) begin
                disp_state_q     <= ENG_BUSY;
                disp_cnt_q       <= '0;
                disp_tile_q      <= head_cmd.tile_addr;
                disp_nv_q        <= head_cmd.nv_cnt;
                disp_ugd_q       <= head_cmd.ugd_vec_size;
                disp_man_q       <= head_cmd.man_4b;
                disp_col_en_q    <= head_cmd.col_en;
                disp_col_start_q <= head_cmd.col_start;
                disp_right_q     <= head_cmd.side;
                disp_bc_q        <= head_cmd.broadcast;
            end else if (disp_busy) begin
                disp_cnt_q <= disp_cnt_q + TW'(1);
                if (disp_done_eff || disp_expire) disp_state_q <= ENG_IDLE;
            end
        end
    end

    // A timeout in the clear cycle wins so the event is never lost.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_q <= 2'b00;
        end else begin
            err_q <= (i_err_clr ? 2'b00 : err_q) | {disp_expire, fetch_expire};
        end
    end

    assign o_fetch_en          = fetch_en_q;
    assign o_fetch_addr        = fetch_addr_q;
    assign o_fetch_len         = fetch_len_q;
    assign o_fetch_target      = fetch_target_q;
    assign o_disp_en           = disp_en_q;
    assign o_disp_tile_addr    = disp_tile_q;
    assign o_disp_man_nv_cnt   = disp_nv_q;
    assign o_disp_ugd_vec_size = disp_ugd_q;
    assign o_disp_man_4b       = disp_man_q;
    assign o_disp_col_en       = disp_col_en_q;
    assign o_disp_col_start    = disp_col_start_q;
    assign o_disp_right        = disp_right_q;
    assign o_disp_broadcast    = disp_bc_q;
    assign o_fetch_busy        = fetch_busy;
    assign o_disp_busy         = disp_busy;
    assign o_idle              = q_empty && !fetch_busy && !disp_busy;
    assign o_cmd_count         = count;
    assign o_err_timeout       = err_q;
endmodule

// File: tb/tb_fetch_dispatch_sequencer.sv
// Directed bench for fetch_dispatch_sequencer: issue latency, side hazards, queue full, watchdog, reset.
module tb_fetch_dispatch_sequencer;
    localparam int AW = 25;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_op, cmd_side;
    logic [AW-1:0] cmd_fetch_addr;
    logic [LW-1:0] cmd_fetch_len;
    logic [15:0]   cmd_tile;
    logic [7:0]    cmd_nv, cmd_ugd;
    logic          cmd_man, cmd_bc;
    logic [23:0]   cmd_col_en;
    logic [4:0]    cmd_col_start;
    logic          fetch_en, fetch_target, fetch_done;
    logic [AW-1:0] fetch_addr;
    logic [LW-1:0] fetch_len;
    logic          disp_en, disp_man, disp_right, disp_bc, disp_done;
    logic [15:0]   disp_tile;
    logic [7:0]    disp_nv, disp_ugd;
    logic [23:0]   disp_col_en;
    logic [4:0]    disp_col_start;
    logic          fetch_busy, disp_busy, idle, err_clr;
    logic [2:0]    cmd_count;
    logic [1:0]    err_timeout;

    int errors = 0;
    int checks = 0;

    fetch_dispatch_sequencer #(
        .CMD_DEPTH(4), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(10)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op), .i_cmd_side(cmd_side),
        .i_cmd_fetch_addr(cmd_fetch_addr), .i_cmd_fetch_len(cmd_fetch_len),
        .i_cmd_tile_addr(cmd_tile), .i_cmd_nv_cnt(cmd_nv), .i_cmd_ugd_vec_size(cmd_ugd),
        .i_cmd_man_4b(cmd_man), .i_cmd_col_en(cmd_col_en), .i_cmd_col_start(cmd_col_start),
        .i_cmd_broadcast(cmd_bc),
        .o_fetch_en(fetch_en), .o_fetch_addr(fetch_addr), .o_fetch_len(fetch_len),
        .o_fetch_target(fetch_target), .i_fetch_done(fetch_done),
        .o_disp_en(disp_en), .o_disp_tile_addr(disp_tile), .o_disp_man_nv_cnt(disp_nv),
        .o_disp_ugd_vec_size(disp_ugd), .o_disp_man_4b(disp_man), .o_disp_col_en(disp_col_en),
        .o_disp_col_start(disp_col_start), .o_disp_right(disp_right), .o_disp_broadcast(disp_bc),
        .i_disp_done(disp_done),
        .o_fetch_busy(fetch_busy), .o_disp_busy(disp_busy), .o_idle(idle),
        .o_cmd_count(cmd_count), .o_err_timeout(err_timeout), .i_err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic side, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_side = side;
        cmd_fetch_addr = addr; cmd_fetch_len = len;
    endtask

    task automatic set_disp(input logic side, input logic [15:0] tile, input logic [7:0] nv,
                            input logic [7:0] ugd, input logic man, input logic [23:0] col_en,
                            input logic [4:0] col_start, input logic bc);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_side = side;
        cmd_tile = tile; cmd_nv = nv; cmd_ugd = ugd; cmd_man = man;
        cmd_col_en = col_en; cmd_col_start = col_start; cmd_bc = bc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_side = 0; cmd_fetch_addr = '0; cmd_fetch_len = '0;
        cmd_tile = '0; cmd_nv = '0; cmd_ugd = '0; cmd_man = 0; cmd_col_en = '0;
        cmd_col_start = '0; cmd_bc = 0; fetch_done = 0; disp_done = 0; err_clr = 0;
        tick(); tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        checks++; if ({fetch_en, disp_en, fetch_busy, disp_busy} !== 4'b0000) begin errors++; $display("FAIL reset_en_busy: got %b expected 0000", {fetch_en, disp_en, fetch_busy, disp_busy}); end
        checks++; if (cmd_count !== 3'd0 || err_timeout !== 2'b00) begin errors++; $display("FAIL reset_count_err: got %0d/%b expected 0/00", cmd_count, err_timeout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch_basic();
        set_fetch(1'b0, 25'h100, 16'd528);
        tick();
        cmd_valid = 1'b0;
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL fetch_latency: got en=%b expected 1", fetch_en); end
        checks++; if (fetch_addr !== 25'h100 || fetch_len !== 16'd528 || fetch_target !== 1'b0) begin errors++; $display("FAIL fetch_args: got %h/%0d/%b expected 100/528/0", fetch_addr, fetch_len, fetch_target); end
        checks++; if (fetch_busy !== 1'b1 || idle !== 1'b0) begin errors++; $display("FAIL fetch_busy_rise: got busy=%b idle=%b expected 1/0", fetch_busy, idle); end
        tick();
        checks++; if (fetch_en !== 1'b0 || fetch_addr !== 25'h100) begin errors++; $display("FAIL fetch_pulse_hold: got en=%b addr=%h expected 0/100", fetch_en, fetch_addr); end
        fetch_done = 1'b1;
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL fetch_busy_at_done: got %b expected 1", fetch_busy); end
        tick();
        fetch_done = 1'b0;
        checks++; if (fetch_busy !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL fetch_release: got busy=%b idle=%b expected 0/1", fetch_busy, idle); end
    endtask

    task automatic test_same_side_hazard();
        int early;
        early = 0;
        set_fetch(1'b0, 25'h400, 16'd16);
        tick();
        set_disp(1'b0, 16'h1234, 8'd128, 8'd16, 1'b1, 24'h00000F, 5'd3, 1'b0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (disp_en !== 1'b0) early++;
            tick();
        end
        fetch_done = 1'b1;
        if (disp_en !== 1'b0) early++;
        checks++; if (early != 0) begin errors++; $display("FAIL hazard_hold: got %0d early enables expected 0", early); end
        tick();
        fetch_done = 1'b0;
        checks++; if (disp_en !== 1'b1) begin errors++; $display("FAIL hazard_release: got disp_en=%b expected 1", disp_en); end
        checks++; if (disp_tile !== 16'h1234 || disp_nv !== 8'd128 || disp_ugd !== 8'd16 || disp_man !== 1'b1) begin errors++; $display("FAIL disp_args_a: got %h/%0d/%0d/%b expected 1234/128/16/1", disp_tile, disp_nv, disp_ugd, disp_man); end
        checks++; if (disp_col_en !== 24'h00000F || disp_col_start !== 5'd3 || disp_right !== 1'b0 || disp_bc !== 1'b0) begin errors++; $display("FAIL disp_args_b: got %h/%0d/%b/%b expected 00000f/3/0/0", disp_col_en, disp_col_start, disp_right, disp_bc); end
        checks++; if (disp_busy !== 1'b1 || fetch_busy !== 1'b0) begin errors++; $display("FAIL hazard_busy: got d=%b f=%b expected 1/0", disp_busy, fetch_busy); end
        tick();
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL hazard_idle: got %b expected 1", idle); end
    endtask

    task automatic test_cross_side();
        set_fetch(1'b1, 25'h050, 16'd8);
        tick();
        checks++; if (fetch_en !== 1'b1 || fetch_target !== 1'b1) begin errors++; $display("FAIL cross_fetch: got en=%b tgt=%b expected 1/1", fetch_en, fetch_target); end
        set_disp(1'b0, 16'h0077, 8'd4, 8'd2, 1'b0, 24'hFFFFFF, 5'd0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        checks++; if (disp_en !== 1'b1 || fetch_busy !== 1'b1 || disp_right !== 1'b0 || disp_bc !== 1'b1) begin errors++; $display("FAIL cross_concurrent: got en=%b fb=%b r=%b bc=%b expected 1/1/0/1", disp_en, fetch_busy, disp_right, disp_bc); end
        fetch_done = 1'b1;
        disp_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        checks++; if (fetch_busy !== 1'b0 || disp_busy !== 1'b1) begin errors++; $display("FAIL done_in_en_cycle: got fb=%b db=%b expected 0/1", fetch_busy, disp_busy); end
        tick();
        disp_done = 1'b0;
        checks++; if (disp_busy !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL cross_idle: got db=%b idle=%b expected 0/1", disp_busy, idle); end
    endtask

    task automatic test_queue_full_order();
        logic        exp_op [4];
        logic [24:0] exp_key [4];
        int k, extra;
        logic f_pend, d_pend;
        exp_op[0] = 1'b1; exp_key[0] = 25'h00A;
        exp_op[1] = 1'b0; exp_key[1] = 25'h200;
        exp_op[2] = 1'b1; exp_key[2] = 25'h00B;
        exp_op[3] = 1'b0; exp_key[3] = 25'h300;
        set_fetch(1'b0, 25'h0AA, 16'd8);
        tick();
        set_disp(1'b0, 16'h000A, 8'd1, 8'd1, 1'b0, 24'h1, 5'd0, 1'b0);
        tick();
        set_fetch(1'b1, 25'h200, 16'd4);
        tick();
        set_disp(1'b1, 16'h000B, 8'd1, 8'd1, 1'b0, 24'h1, 5'd0, 1'b0);
        tick();
        checks++; if (cmd_ready !== 1'b1 || cmd_count !== 3'd3) begin errors++; $display("FAIL q_three: got rdy=%b cnt=%0d expected 1/3", cmd_ready, cmd_count); end
        set_fetch(1'b0, 25'h300, 16'd4);
        tick();
        checks++; if (cmd_ready !== 1'b0 || cmd_count !== 3'd4) begin errors++; $display("FAIL q_full: got rdy=%b cnt=%0d expected 0/4", cmd_ready, cmd_count); end
        set_fetch(1'b0, 25'h999, 16'd4);
        tick();
        cmd_valid = 1'b0;
        checks++; if (cmd_count !== 3'd4 || disp_en !== 1'b0) begin errors++; $display("FAIL q_drop: got cnt=%0d den=%b expected 4/0", cmd_count, disp_en); end
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        k = 0; f_pend = 1'b0; d_pend = 1'b0;
        for (int cyc = 0; cyc < 40 && (k < 4 || f_pend || d_pend); cyc++) begin
            fetch_done = f_pend; disp_done = d_pend;
            f_pend = 1'b0; d_pend = 1'b0;
            if (fetch_en === 1'b1) begin
                checks++;
                if (k >= 4) begin errors++; $display("FAIL order_extra_fetch: got addr=%h expected none", fetch_addr); end
                else if (exp_op[k] !== 1'b0 || fetch_addr !== exp_key[k]) begin errors++; $display("FAIL order_fetch%0d: got addr=%h expected op=%b key=%h", k, fetch_addr, exp_op[k], exp_key[k]); end
                k++; f_pend = 1'b1;
            end
            if (disp_en === 1'b1) begin
                checks++;
                if (k >= 4) begin errors++; $display("FAIL order_extra_disp: got tile=%h expected none", disp_tile); end
                else if (exp_op[k] !== 1'b1 || {9'd0, disp_tile} !== exp_key[k]) begin errors++; $display("FAIL order_disp%0d: got tile=%h expected op=%b key=%h", k, disp_tile, exp_op[k], exp_key[k]); end
                k++; d_pend = 1'b1;
            end
            tick();
        end
        fetch_done = 1'b0; disp_done = 1'b0;
        checks++; if (k != 4) begin errors++; $display("FAIL order_count: got %0d issues expected 4", k); end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            if (fetch_en === 1'b1 || disp_en === 1'b1) extra++;
            tick();
        end
        checks++; if (extra != 0 || idle !== 1'b1 || cmd_count !== 3'd0) begin errors++; $display("FAIL q_drained: got extra=%0d idle=%b cnt=%0d expected 0/1/0", extra, idle, cmd_count); end
    endtask

    task automatic test_timeout();
        set_fetch(1'b0, 25'h0C0, 16'd4);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (fetch_busy !== 1'b1 || err_timeout !== 2'b00) begin errors++; $display("FAIL wdog_before: got busy=%b err=%b expected 1/00", fetch_busy, err_timeout); end
        tick();
        checks++; if (fetch_busy !== 1'b0 || err_timeout !== 2'b01) begin errors++; $display("FAIL wdog_expire: got busy=%b err=%b expected 0/01", fetch_busy, err_timeout); end
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        checks++; if (fetch_busy !== 1'b0 || fetch_en !== 1'b0 || err_timeout !== 2'b01) begin errors++; $display("FAIL wdog_late_done: got busy=%b en=%b err=%b expected 0/0/01", fetch_busy, fetch_en, err_timeout); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_timeout !== 2'b00 || idle !== 1'b1) begin errors++; $display("FAIL wdog_clear: got err=%b idle=%b expected 00/1", err_timeout, idle); end
    endtask

    task automatic test_reset_midop();
        set_disp(1'b0, 16'h0300, 8'd2, 8'd2, 1'b0, 24'h3, 5'd1, 1'b0);
        tick();
        set_fetch(1'b0, 25'h310, 16'd4);
        tick();
        set_disp(1'b1, 16'h0320, 8'd2, 8'd2, 1'b0, 24'h3, 5'd1, 1'b0);
        tick();
        cmd_valid = 1'b0;
        checks++; if (cmd_count !== 3'd2 || disp_busy !== 1'b1) begin errors++; $display("FAIL midop_setup: got cnt=%0d db=%b expected 2/1", cmd_count, disp_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (cmd_count !== 3'd0 || idle !== 1'b1 || disp_busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL midop_reset: got cnt=%0d idle=%b db=%b rdy=%b expected 0/1/0/1", cmd_count, idle, disp_busy, cmd_ready); end
        tick();
        checks++; if (fetch_en !== 1'b0 || disp_en !== 1'b0) begin errors++; $display("FAIL midop_no_en: got fen=%b den=%b expected 0/0", fetch_en, disp_en); end
        rst_n = 1'b1;
        tick();
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
        tick();
        checks++; if (fetch_en !== 1'b0 || disp_en !== 1'b0 || disp_busy !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL midop_stray_done: got fen=%b den=%b db=%b idle=%b expected 0/0/0/1", fetch_en, disp_en, disp_busy, idle); end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_same_side_hazard();
        test_cross_side();
        test_queue_full_order();
        test_timeout();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
